// File: rtl/div_seq_pkg.sv
// Shared definitions for the EX-stage sequential divider: FSM encoding and
// default geometry.
package div_seq_pkg;

  localparam int DIV_WIDTH  = 32;
  localparam int DIV_CYCLES = DIV_WIDTH;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_SIGN = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

endpackage : div_seq_pkg

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] trial;

  // The shifted remainder needs WIDTH+1 bits; when the divisor fits, the
  // difference is below 2^WIDTH, so a WIDTH-bit subtract is exact.
  always_comb begin
    shifted = {rem_i, bit_i};
    trial   = shifted[WIDTH-1:0] - divisor_i;
    q_bit_o = (shifted >= {1'b0, divisor_i});
    rem_o   = q_bit_o ? trial : shifted[WIDTH-1:0];
  end

endmodule : div_step

// File: rtl/div_seq.sv
// Multi-cycle DIV/DIVU sequencer: magnitude restoring divide over WIDTH
// cycles, sign fix-up, then a one-cycle ready pulse for the hazard unit.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 annul,
  input  logic                 signed_div,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   result,
  output logic                 ready,
  output logic                 busy
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_e       state_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic             neg_quo_q, neg_rem_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH-1:0] a_mag, b_mag, rem_step, q_fix, r_fix;
  logic             q_bit, a_neg, b_neg;

  always_comb begin
    a_neg = signed_div & a[WIDTH-1];
    b_neg = signed_div & b[WIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
    q_fix = neg_quo_q ? -quo_q : quo_q;
    r_fix = neg_rem_q ? -rem_q : rem_q;
  end

  // Dividend shifts out of quo_q's MSB while quotient bits shift into its LSB.
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .bit_i     (quo_q[WIDTH-1]),
    .divisor_i (dvs_q),
    .rem_o     (rem_step),
    .q_bit_o   (q_bit)
  );

  // NOTE: state lives in one clocked block with non-blocking assignments so
  // every register updates from pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DIV_IDLE;
      ready     <= 1'b0;
      busy      <= 1'b0;
      result    <= '0;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state_q)
        DIV_IDLE: begin
          if (start && !annul) begin
            rem_q     <= '0;
            quo_q     <= a_mag;
            dvs_q     <= b_mag;
            // A zero divisor leaves the all-ones quotient unsigned.
            neg_quo_q <= (a_neg ^ b_neg) && (b != '0);
            neg_rem_q <= a_neg;
            cnt_q     <= '0;
            busy      <= 1'b1;
            state_q   <= DIV_RUN;
          end
        end
        DIV_RUN: begin
          if (annul) begin
            busy    <= 1'b0;
            state_q <= DIV_IDLE;
          end else begin
            rem_q <= rem_step;
            quo_q <= {quo_q[WIDTH-2:0], q_bit};
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) state_q <= DIV_SIGN;
          end
        end
        DIV_SIGN: begin
          if (annul) begin
            busy    <= 1'b0;
            state_q <= DIV_IDLE;
          end else begin
            result  <= {r_fix, q_fix};
            ready   <= 1'b1;
            state_q <= DIV_DONE;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_q <= DIV_IDLE;
        end
      endcase
    end
  end

endmodule : div_seq
